// File: rtl/hermes_tx_stage.sv
// Hermes output stage: buffers DMNI flits in a small FIFO, forwards them to the
// router under credit flow control, and checks packet framing on the way in.
module hermes_tx_stage #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dmni_tx_i,
  input  logic                 dmni_eop_i,
  output logic                 dmni_credit_o,
  input  logic [FLIT_SIZE-1:0] dmni_data_i,
  output logic                 noc_tx_o,
  output logic                 noc_eop_o,
  input  logic                 noc_credit_i,
  output logic [FLIT_SIZE-1:0] noc_data_o,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] pkt_count_o,
  output logic [CNT_WIDTH-1:0] flit_count_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  typedef enum logic [1:0] {
    HEADER,
    SIZE,
    PAYLOAD
  } state_t;

  logic [FLIT_SIZE:0] mem [BUFFER_SIZE];
  logic [FLIT_SIZE:0] head;
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               full, empty, push, pop;

  state_t             state_q, state_d;
  logic [15:0]        rem_q, rem_d;
  logic [15:0]        size_field;
  logic               err;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = dmni_tx_i && !full;
  assign pop   = !empty && noc_credit_i;

  assign dmni_credit_o = !full;
  assign head          = mem[rd_ptr[PTR_W-1:0]];
  assign noc_tx_o      = !empty;
  assign noc_eop_o     = !empty && head[FLIT_SIZE];
  assign noc_data_o    = empty ? '0 : head[FLIT_SIZE-1:0];
  assign busy_o        = !empty || (state_q != HEADER);

  // NOTE: storage has no reset; outputs are masked while empty so stale
  // contents never reach the router.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {dmni_eop_i, dmni_data_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state_q <= HEADER;
      rem_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign size_field = dmni_data_i[15:0];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err     = 1'b0;
    if (push) begin
      unique case (state_q)
        HEADER: begin
          if (dmni_eop_i) err = 1'b1;
          else            state_d = SIZE;
        end
        SIZE: begin
          if (size_field == '0) begin
            if (dmni_eop_i) begin
              state_d = HEADER;
            end else begin
              err     = 1'b1;
              state_d = PAYLOAD;
              rem_d   = '0;
            end
          end else if (dmni_eop_i) begin
            err     = 1'b1;
            state_d = HEADER;
          end else begin
            state_d = PAYLOAD;
            rem_d   = size_field;
          end
        end
        PAYLOAD: begin
          if (dmni_eop_i) begin
            err     = (rem_q != 16'd1);
            state_d = HEADER;
            rem_d   = '0;
          end else if (rem_q == 16'd1) begin
            err   = 1'b1;
            rem_d = '0;
          end else if (rem_q != '0) begin
            rem_d = rem_q - 16'd1;
          end
        end
        default: state_d = HEADER;
      endcase
    end
  end

  // Clear takes priority over any same-cycle count or error event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_count_o  <= '0;
      flit_count_o <= '0;
      frame_err_o  <= 1'b0;
    end else if (clear_i) begin
      pkt_count_o  <= '0;
      flit_count_o <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      if (push)               flit_count_o <= flit_count_o + 1'b1;
      if (push && dmni_eop_i) pkt_count_o  <= pkt_count_o + 1'b1;
      if (err)                frame_err_o  <= 1'b1;
    end
  end

endmodule
